// File: rtl/sms_timing_ring_if.sv
// Control/strobe bundle between the timing ring and its consumers
// (sequencer drives the controls, RS latch cards take the strobes).
interface sms_timing_ring_if;
  logic       start;
  logic       stop;
  logic       single_cycle;
  logic [9:0] t_ring;
  logic       running;
  logic       cycle_end;
  logic       latch_set_n;
  logic       latch_reset_n;

  modport master (
    output start, stop, single_cycle,
    input  t_ring, running, cycle_end, latch_set_n, latch_reset_n
  );

  modport slave (
    input  start, stop, single_cycle,
    output t_ring, running, cycle_end, latch_set_n, latch_reset_n
  );
endinterface

// File: rtl/sms_timing_ring.sv
// 1620 memory-cycle timing ring: ten one-hot intervals T-A..T-J with
// single-clock active-low set/reset strobes and a cycle-end pulse.
module sms_timing_ring #(
  parameter int unsigned TICKS_PER_STEP = 100,
  parameter int unsigned SET_STEP       = 0,
  parameter int unsigned RESET_STEP     = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  sms_timing_ring_if.slave       bus
);

  localparam int unsigned TW       = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [TW-1:0] TickLast = TW'(TICKS_PER_STEP - 1);
  localparam logic [3:0]    StepLast = 4'd9;
  localparam logic [3:0]    SetStep  = 4'(SET_STEP);
  localparam logic [3:0]    RstStep  = 4'(RESET_STEP);

  if (TICKS_PER_STEP < 2 || SET_STEP > 9 || RESET_STEP > 9 || SET_STEP == RESET_STEP) begin : g_bad
    $fatal(1, "sms_timing_ring: illegal parameter combination");
  end

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [3:0]    step_q, step_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          stop_pend_q, stop_pend_d;

  logic [9:0]    t_ring_q, t_ring_d;
  logic          running_q, running_d;
  logic          cycle_end_q, cycle_end_d;
  logic          set_n_q, set_n_d;
  logic          reset_n_q, reset_n_d;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    tick_d      = tick_q;
    stop_pend_d = stop_pend_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.stop) begin
          state_d = StRun;
          step_d  = '0;
          tick_d  = '0;
        end
      end
      StRun: begin
        if (bus.stop) stop_pend_d = 1'b1;
        if (tick_q == TickLast) begin
          tick_d = '0;
          if (step_q == StepLast) begin
            step_d = '0;
            // Halt requests only take effect on the memory-cycle boundary.
            if (stop_pend_q || bus.stop || bus.single_cycle) begin
              state_d     = StIdle;
              stop_pend_d = 1'b0;
            end
          end else begin
            step_d = step_q + 4'd1;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from next state so they line up with the interval
  // they describe while remaining registered.
  always_comb begin
    running_d   = (state_d == StRun);
    t_ring_d    = running_d ? (10'b1 << step_d) : '0;
    cycle_end_d = running_d && (step_d == StepLast) && (tick_d == TickLast);
    set_n_d     = !(running_d && (step_d == SetStep) && (tick_d == '0));
    reset_n_d   = !(running_d && (step_d == RstStep) && (tick_d == '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      step_q      <= '0;
      tick_q      <= '0;
      stop_pend_q <= 1'b0;
      t_ring_q    <= '0;
      running_q   <= 1'b0;
      cycle_end_q <= 1'b0;
      set_n_q     <= 1'b1;
      reset_n_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      tick_q      <= tick_d;
      stop_pend_q <= stop_pend_d;
      t_ring_q    <= t_ring_d;
      running_q   <= running_d;
      cycle_end_q <= cycle_end_d;
      set_n_q     <= set_n_d;
      reset_n_q   <= reset_n_d;
    end
  end

  assign bus.t_ring        = t_ring_q;
  assign bus.running       = running_q;
  assign bus.cycle_end     = cycle_end_q;
  assign bus.latch_set_n   = set_n_q;
  assign bus.latch_reset_n = reset_n_q;

endmodule

// File: tb/tb_sms_timing_ring.sv
// Bench for sms_timing_ring: directed scenarios plus random control traffic,
// compared each clock against a cycle-position reference model.
module tb_sms_timing_ring;

  localparam int unsigned Tps      = 4;
  localparam int unsigned SetStep  = 0;
  localparam int unsigned RstStep  = 5;
  localparam int          CycleLen = 10 * Tps;

  logic clk;
  logic reset;

  sms_timing_ring_if ring_if ();

  sms_timing_ring #(
    .TICKS_PER_STEP (Tps),
    .SET_STEP       (SetStep),
    .RESET_STEP     (RstStep)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ring_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: a ring is just a position 0..CycleLen-1 within a memory cycle.
  bit m_run  = 1'b0;
  int m_pos  = 0;
  bit m_pend = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
  endtask

  task automatic model_step(input bit st, input bit sp, input bit sc, input bit rs);
    if (rs) begin
      m_run = 0; m_pos = 0; m_pend = 0;
    end else if (!m_run) begin
      if (st && !sp) begin m_run = 1; m_pos = 0; end
    end else if (m_pos == CycleLen - 1) begin
      if (m_pend || sp || sc) begin m_run = 0; m_pend = 0; end
      m_pos = 0;
    end else begin
      m_pos++;
      if (sp) m_pend = 1;
    end
  endtask

  task automatic compare_outputs();
    logic [9:0] exp_ring;
    exp_ring = m_run ? 10'(1 << (m_pos / Tps)) : 10'd0;
    check_eq("t_ring",        32'(ring_if.t_ring),        32'(exp_ring));
    check_eq("running",       32'(ring_if.running),       32'(m_run));
    check_eq("cycle_end",     32'(ring_if.cycle_end),     32'(m_run && m_pos == CycleLen - 1));
    check_eq("latch_set_n",   32'(ring_if.latch_set_n),
             32'(!(m_run && m_pos == int'(SetStep * Tps))));
    check_eq("latch_reset_n", 32'(ring_if.latch_reset_n),
             32'(!(m_run && m_pos == int'(RstStep * Tps))));
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rise.
  task automatic clock(input bit st, input bit sp, input bit sc, input bit rs);
    @(negedge clk);
    ring_if.start        = st;
    ring_if.stop         = sp;
    ring_if.single_cycle = sc;
    reset                = rs;
    @(posedge clk);
    model_step(st, sp, sc, rs);
    #1;
    compare_outputs();
  endtask

  task automatic idle_clocks(input int n);
    for (int i = 0; i < n; i++) clock(0, 0, 0, 0);
  endtask

  // Advance until the reference is at cycle position pos; expiry is a failure.
  task automatic run_to_pos(input int pos);
    int k;
    k = 0;
    while (!(m_run && m_pos == pos) && k < 3 * CycleLen) begin
      clock(0, 0, 0, 0);
      k++;
    end
    check_eq("reach_pos", 32'(m_run && m_pos == pos), 32'd1);
  endtask

  initial begin
    ring_if.start = 0; ring_if.stop = 0; ring_if.single_cycle = 0; reset = 1;

    for (int i = 0; i < 3; i++) clock(0, 0, 0, 1);
    idle_clocks(10);

    // Free-running cycles after a single start pulse.
    clock(1, 0, 0, 0);
    idle_clocks(90);

    // Stop pulse mid-cycle: cycle completes before halting.
    run_to_pos(12);
    clock(0, 1, 0, 0);
    idle_clocks(CycleLen);
    check_eq("halted_after_stop", 32'(ring_if.running), 32'd0);

    // single_cycle held: exactly one cycle.
    clock(1, 0, 1, 0);
    for (int i = 0; i < CycleLen + 6; i++) clock(0, 0, 1, 0);
    check_eq("halted_single", 32'(ring_if.running), 32'd0);

    // start+stop together in idle, then start re-pulsed mid-run.
    clock(1, 1, 0, 0);
    idle_clocks(3);
    clock(1, 0, 0, 0);
    run_to_pos(17);
    clock(1, 0, 0, 0);
    idle_clocks(50);

    // Reset during T-F, then a clean restart.
    run_to_pos(22);
    clock(0, 0, 0, 1);
    idle_clocks(3);
    clock(1, 0, 0, 0);
    idle_clocks(12);

    // Back-to-back: start held through a halting boundary.
    run_to_pos(30);
    clock(0, 1, 0, 0);
    for (int i = 0; i < 15; i++) clock(1, 0, 0, 0);

    // Random control traffic.
    for (int i = 0; i < 3000; i++) begin
      clock(($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 29) == 0), ($urandom_range(0, 399) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
